// File: rtl/vec_sequencer_if.sv
// Bus bundle between vec_sequencer and whatever drives it / sits around circuit3.
// master = driver side (table load, start, circuit3 results); slave = the sequencer.
interface vec_sequencer_if #(
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [5:0]        wr_data;
   logic [ADDR_W:0]   num_vecs;
   logic              start;
   logic [2:0]        i1;
   logic              i2;
   logic              sum_in;
   logic              cout_in;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] vec_idx;
   logic              mismatch;
   logic [CNT_W-1:0]  pass_cnt;
   logic [CNT_W-1:0]  fail_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, num_vecs, start, sum_in, cout_in,
      input  i1, i2, busy, done, vec_idx, mismatch, pass_cnt, fail_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, num_vecs, start, sum_in, cout_in,
      output i1, i2, busy, done, vec_idx, mismatch, pass_cnt, fail_cnt
   );
endinterface

// File: rtl/vec_sequencer.sv
// Applies a small table of {i1,i2,exp_sum,exp_cout} vectors to circuit3 and checks its outputs.
// Define VEC_SEQ_STOP_ON_FAIL_EN to end the run at the first failing compare.
module vec_sequencer #(
   parameter int ADDR_W = 3,
   parameter int GAP    = 10,
   parameter int CNT_W  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   vec_sequencer_if.slave bus
);
   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   DEPTH_N  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_N    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [7:0]        GAP_LOAD = 8'(GAP - 1);
   localparam logic [7:0]        ONE_G    = 8'd1;
   localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            r_state,   w_state_next;
   logic [2:0]        r_i1,      w_i1_next;
   logic              r_i2,      w_i2_next;
   logic [ADDR_W-1:0] r_vec_idx, w_vec_idx_next;
   logic [ADDR_W:0]   r_num,     w_num_next;
   logic [7:0]        r_gap,     w_gap_next;
   logic [CNT_W-1:0]  r_pass,    w_pass_next;
   logic [CNT_W-1:0]  r_fail,    w_fail_next;

   logic [5:0]        r_table [DEPTH];

   logic [5:0]        w_entry;
   logic              w_match;
   logic              w_last;
   logic              w_idle_like;
   logic [ADDR_W:0]   w_num_clamp;

   assign w_entry     = r_table[r_vec_idx];
   assign w_match     = ({bus.sum_in, bus.cout_in} == w_entry[1:0]);
   assign w_last      = ({1'b0, r_vec_idx} == (r_num - ONE_N));
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_num_clamp = (bus.num_vecs > DEPTH_N) ? DEPTH_N : bus.num_vecs;

   // Table has no reset; writes are locked out while a run is in flight.
   always_ff @(posedge clk) begin
      if (w_idle_like && bus.wr_en) begin
         r_table[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_i1      <= 3'd0;
         r_i2      <= 1'b0;
         r_vec_idx <= '0;
         r_num     <= '0;
         r_gap     <= 8'd0;
         r_pass    <= '0;
         r_fail    <= '0;
      end else begin
         r_state   <= w_state_next;
         r_i1      <= w_i1_next;
         r_i2      <= w_i2_next;
         r_vec_idx <= w_vec_idx_next;
         r_num     <= w_num_next;
         r_gap     <= w_gap_next;
         r_pass    <= w_pass_next;
         r_fail    <= w_fail_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_i1_next      = r_i1;
      w_i2_next      = r_i2;
      w_vec_idx_next = r_vec_idx;
      w_num_next     = r_num;
      w_gap_next     = r_gap;
      w_pass_next    = r_pass;
      w_fail_next    = r_fail;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_num_next     = w_num_clamp;
               w_pass_next    = '0;
               w_fail_next    = '0;
               w_vec_idx_next = '0;
               w_state_next   = (w_num_clamp == '0) ? S_DONE : S_APPLY;
            end
         end
         S_APPLY: begin
            w_i1_next    = w_entry[5:3];
            w_i2_next    = w_entry[2];
            w_gap_next   = GAP_LOAD;
            // With a one-cycle gap the compare edge directly follows the apply edge.
            w_state_next = (GAP == 1) ? S_CHECK : S_WAIT;
         end
         S_WAIT: begin
            w_gap_next = r_gap - ONE_G;
            if (r_gap == ONE_G) begin
               w_state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (w_match) begin
               w_pass_next = (r_pass == CNT_MAX) ? r_pass : r_pass + ONE_C;
            end else begin
               w_fail_next = (r_fail == CNT_MAX) ? r_fail : r_fail + ONE_C;
            end
`ifdef VEC_SEQ_STOP_ON_FAIL_EN
            if (w_last || !w_match) begin
`else
            if (w_last) begin
`endif
               w_state_next = S_DONE;
            end else begin
               w_vec_idx_next = r_vec_idx + ONE_A;
               w_state_next   = S_APPLY;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign bus.i1       = r_i1;
   assign bus.i2       = r_i2;
   assign bus.busy     = (r_state == S_APPLY) || (r_state == S_WAIT) || (r_state == S_CHECK);
   assign bus.done     = (r_state == S_DONE);
   assign bus.vec_idx  = r_vec_idx;
   assign bus.mismatch = (r_state == S_CHECK) && !w_match;
   assign bus.pass_cnt = r_pass;
   assign bus.fail_cnt = r_fail;
endmodule

// File: doc/vec_sequencer.md
Name: vec_sequencer

Overview:
- Clocked stimulus/check stage that sits directly upstream of circuit3 and also consumes its outputs.
- Holds a small writable table of vectors. Each entry is {i1[2:0], i2, exp_sum, exp_cout}.
- On start it applies entries in order to circuit3's i1/i2 inputs. After each one it waits a settle gap, then samples sum1/cout1 and checks them against the expected bits.
- Keeps pass/fail counts and flags every mismatch, so a bench or top-level can self-check circuit3 without hand-inspecting $monitor output.

Parameters:
- ADDR_W, 3: table address width; DEPTH = 2**ADDR_W = 8 entries.
- GAP, 10: settle cycles between applying a vector and sampling the result; legal range 1..255.
- CNT_W, 8: width of the pass/fail counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  table write address
- wr_data  in  6  {i1[2:0], i2, exp_sum, exp_cout}
- num_vecs  in  ADDR_W+1  number of entries to run; clamped to DEPTH
- start  in  1  one-cycle start pulse
- i1  out  3  to circuit3 i1
- i2  out  1  to circuit3 i2
- sum_in  in  1  from circuit3 sum1
- cout_in  in  1  from circuit3 cout1
- busy  out  1  run in progress
- done  out  1  run complete; held until the next start
- vec_idx  out  ADDR_W  index of the current or last checked entry
- mismatch  out  1  one-cycle pulse on a failed compare
- pass_cnt  out  CNT_W  passing compares, saturating
- fail_cnt  out  CNT_W  failing compares, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; i1=0, i2=0, busy=0, done=0, vec_idx=0, mismatch=0, pass_cnt=0, fail_cnt=0. Table contents are not reset. Reset mid-run aborts the run immediately with no partial compare.
- Table writes: accepted when busy=0 and done-or-IDLE, with wr_en=1; the write lands at the edge. wr_en while busy=1 is ignored. A write and a start in the same cycle: the write completes first, and the run sees the new entry.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE:
  - start=1 with clamped num_vecs=0 goes to DONE (done=1, counters cleared).
  - start=1 with num_vecs>0 clears the counters, sets vec_idx=0 and busy=1, and goes to APPLY.
- APPLY: registers {i1,i2}=table[vec_idx][5:2], loads the gap counter with GAP-1, goes to WAIT.
- WAIT: decrements the gap counter; when it reaches 0, goes to CHECK.
- CHECK:
  - Samples {sum_in,cout_in} and compares it with table[vec_idx][1:0].
  - Equal: pass_cnt+1. Unequal: fail_cnt+1 and mismatch=1 for that cycle. Both counters saturate at all-ones.
  - If vec_idx == num_vecs-1, goes to DONE (busy=0, done=1). Otherwise vec_idx+1 and back to APPLY.
- Timing:
  - start sampled at edge E0; vector 0 appears on i1/i2 at E1.
  - Compare samples at edge E1+GAP.
  - The next vector appears at E1+GAP+1, so the vector period is GAP+1 cycles.
  - done rises at the edge after the last compare.
- i1/i2 hold the last applied vector in DONE. They return to 0 only on reset.
- start while busy=1 is ignored. start in DONE restarts the run and drops done at that edge.
- num_vecs is sampled only at start; later changes have no effect on the current run.

Optional Feature:
- Macro: VEC_SEQ_STOP_ON_FAIL_EN.
- Defined: a failing CHECK goes straight to DONE. vec_idx holds the failing index and fail_cnt=1; the remaining entries are not applied.
- Undefined: every entry runs regardless of mismatches.

Test Plan:
- Load 4 entries {000,0,e0},{001,1,e1},{010,0,e2},{011,1,e3}, with the expected bits matching a reference model of circuit3; num_vecs=4, GAP=10, start -> i1/i2 step every 11 cycles; done after 44 cycles post-start; pass_cnt=4, fail_cnt=0, no mismatch pulse.
- Same table but entry 2's expected bits inverted -> exactly one mismatch pulse, during the entry 2 CHECK cycle; pass_cnt=3, fail_cnt=1. With VEC_SEQ_STOP_ON_FAIL_EN: done after entry 2, vec_idx=2, pass_cnt=2, fail_cnt=1, i1/i2 held at 010/0.
- num_vecs=0, start -> done=1 on the next edge; busy never asserts; i1/i2 stay 0.
- num_vecs=15 with DEPTH=8 -> exactly 8 compares; vec_idx ends at 7; pass_cnt+fail_cnt=8.
- rst_n pulled low in WAIT of entry 1 -> all outputs 0 immediately. After release, start reruns from entry 0 with the table contents intact.
- wr_en during busy to entry 3 with a new value -> the entry is unchanged. start pulses while busy -> no restart; counters continue.
